seq_multiplier_32bit: RTL and testbench

SEQ_MULTIPLIER_32BIT -- requirements
Module: seq_multiplier_32bit

---
 rtl/seq_multiplier_32bit.sv | 150 +++++++++++++++
 tb/tb_seq_multiplier_32bit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier_32bit.sv
// Sequential 32x32 -> 64-bit shift-add multiplier: one step per clock, 32 steps per product.
// Optional macro MUL_SIGNED_EN adds signed_i for two's-complement operands.
module seq_multiplier_32bit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] A_i,
    input  logic [31:0] Y_i,
`ifdef MUL_SIGNED_EN
    input  logic        signed_i,
`endif
    output logic        busy_o,
    output logic        done_o,
    output logic [63:0] Prod_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] m_reg, m_next;
    logic [31:0] p_hi_reg, p_hi_next;
    logic [31:0] p_lo_reg, p_lo_next;
    logic [4:0]  count_reg, count_next;
    logic [63:0] prod_reg, prod_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;

    logic        start_ok;
    logic [31:0] a_mag;
    logic [31:0] y_mag;
    logic [32:0] sum;
    logic [63:0] step_result;
    logic [63:0] final_result;

`ifdef MUL_SIGNED_EN
    logic        neg_reg, neg_next;

    // Magnitudes feed the unsigned datapath; 0x80000000 negates to itself, which is exactly 2^31.
    always_comb begin
        a_mag    = (signed_i && A_i[31]) ? (~A_i + 32'd1) : A_i;
        y_mag    = (signed_i && Y_i[31]) ? (~Y_i + 32'd1) : Y_i;
        neg_next = neg_reg;
        if (start_ok) begin
            neg_next = signed_i && (A_i[31] ^ Y_i[31]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            neg_reg <= 1'b0;
        end else begin
            neg_reg <= neg_next;
        end
    end

    assign final_result = neg_reg ? (~step_result + 64'd1) : step_result;
`else
    assign a_mag        = A_i;
    assign y_mag        = Y_i;
    assign final_result = step_result;
`endif

    // A new operation may start from IDLE or straight out of DONE.
    assign start_ok = start_i && (state_reg != BUSY);

    // The 33rd sum bit is the step's carry-out and becomes the new top bit of P_hi.
    always_comb begin
        sum         = p_lo_reg[0] ? ({1'b0, p_hi_reg} + {1'b0, m_reg}) : {1'b0, p_hi_reg};
        step_result = {sum, p_lo_reg[31:1]};
    end

    always_comb begin
        state_next = state_reg;
        m_next     = m_reg;
        p_hi_next  = p_hi_reg;
        p_lo_next  = p_lo_reg;
        count_next = count_reg;
        prod_next  = prod_reg;

        case (state_reg)
            IDLE: begin
                if (start_ok) begin
                    state_next = BUSY;
                    m_next     = a_mag;
                    p_hi_next  = 32'd0;
                    p_lo_next  = y_mag;
                    count_next = 5'd0;
                end
            end
            BUSY: begin
                p_hi_next  = step_result[63:32];
                p_lo_next  = step_result[31:0];
                count_next = count_reg + 5'd1;
                if (count_reg == 5'd31) begin
                    state_next = DONE;
                    prod_next  = final_result;
                end
            end
            DONE: begin
                if (start_ok) begin
                    state_next = BUSY;
                    m_next     = a_mag;
                    p_hi_next  = 32'd0;
                    p_lo_next  = y_mag;
                    count_next = 5'd0;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Flags are registered copies of the upcoming state so they align with it.
        busy_next = (state_next == BUSY);
        done_next = (state_next == DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            m_reg     <= 32'd0;
            p_hi_reg  <= 32'd0;
            p_lo_reg  <= 32'd0;
            count_reg <= 5'd0;
            prod_reg  <= 64'd0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            m_reg     <= m_next;
            p_hi_reg  <= p_hi_next;
            p_lo_reg  <= p_lo_next;
            count_reg <= count_next;
            prod_reg  <= prod_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign busy_o = busy_reg;
    assign done_o = done_reg;
    assign Prod_o = prod_reg;

endmodule

// File: tb/tb_seq_multiplier_32bit.sv
// Scoreboard bench for seq_multiplier_32bit: stimulus pushes expected products, a monitor pops them on done_o.
// Signed vectors are included when MUL_SIGNED_EN is defined.
module tb_seq_multiplier_32bit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] y;
    logic        sgn;
    logic        busy;
    logic        done;
    logic [63:0] prod;

    int tests = 0;
    int fails = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    seq_multiplier_32bit dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .A_i     (a),
        .Y_i     (y),
`ifdef MUL_SIGNED_EN
        .signed_i(sgn),
`endif
        .busy_o  (busy),
        .done_o  (done),
        .Prod_o  (prod)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, req);
        end
    endtask

    // Monitor: every done_o pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        logic [63:0] e;
        if (done === 1'b1) begin
            check("busy_with_done", {63'd0, busy}, 64'd0);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got product 0x%h, expected no done pulse", prod);
            end else begin
                e = exp_q.pop_front();
                check("product", prod, e);
                $display("[TB] result 0x%h (expected 0x%h)", prod, e);
            end
        end
    end

    task automatic issue(input logic [31:0] av, input logic [31:0] yv, input logic sv,
                         input logic [63:0] ev, input logic push);
        a     = av;
        y     = yv;
        sgn   = sv;
        start = 1'b1;
        if (push) exp_q.push_back(ev);
    endtask

    // Called at the negedge right after the accepting edge; checks n busy cycles then the done cycle.
    task automatic wait_done(input int n_busy, input string name);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < n_busy; i++) begin
            if (!(busy === 1'b1 && done === 1'b0)) bad = 1'b1;
            @(negedge clk);
        end
        check({name, "_busy_window"}, {63'd0, bad}, 64'd0);
        check({name, "_done_cycle"}, {62'd0, busy, done}, 64'd1);
    endtask

    task automatic run_op(input logic [31:0] av, input logic [31:0] yv, input logic sv,
                          input logic [63:0] ev, input string name);
        @(negedge clk);
        issue(av, yv, sv, ev, 1'b1);
        @(negedge clk);
        start = 1'b0;
        wait_done(32, name);
        @(negedge clk);
        check({name, "_after"}, {62'd0, busy, done}, 64'd0);
        check({name, "_hold"}, prod, ev);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL timeout: got no completion, expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic seen;
        rst   = 1'b1;
        start = 1'b1;
        a     = 32'd9;
        y     = 32'd9;
        sgn   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_prod", prod, 64'd0);
        start = 1'b0;
        rst   = 1'b0;

        run_op(32'd7, 32'd6, 1'b0, 64'h000000000000002A, "mul_7x6");
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, "mul_max");
        run_op(32'h00010000, 32'h00010000, 1'b0, 64'h0000000100000000, "mul_2p16");
        run_op(32'h80000000, 32'd2, 1'b0, 64'h0000000100000000, "mul_msb_x2");
        run_op(32'd1, 32'hFFFFFFFF, 1'b0, 64'h00000000FFFFFFFF, "mul_1xmax");

        // start held high through BUSY with new operands, then back-to-back from DONE
        @(negedge clk);
        issue(32'h12345678, 32'd0, 1'b0, 64'd0, 1'b1);
        @(negedge clk);
        a = 32'd3;
        y = 32'd3;
        exp_q.push_back(64'd9);
        wait_done(32, "held_start");
        @(negedge clk);
        start = 1'b0;
        wait_done(32, "back_to_back");
        @(negedge clk);
        check("back_to_back_after", {62'd0, busy, done}, 64'd0);
        check("back_to_back_hold", prod, 64'd9);

        // reset during iteration 11 aborts the 5*5 operation
        @(negedge clk);
        issue(32'd5, 32'd5, 1'b0, 64'd0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_prod", prod, 64'd0);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        check("abort_quiet", {63'd0, seen}, 64'd0);
        run_op(32'd2, 32'd3, 1'b0, 64'd6, "mul_2x3");

`ifdef MUL_SIGNED_EN
        run_op(32'hFFFFFFFD, 32'd5, 1'b1, 64'hFFFFFFFFFFFFFFF1, "smul_m3x5");
        run_op(32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, "smul_min_sq");
        run_op(32'hFFFFFFF9, 32'hFFFFFFFA, 1'b1, 64'h000000000000002A, "smul_m7xm6");
        run_op(32'hFFFFFFFF, 32'd2, 1'b0, 64'h00000001FFFFFFFE, "umul_maxx2");
`endif

        repeat (3) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
